alu_muldiv_exec: RTL and testbench
==================================

Name: alu_muldiv_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU_Control code from the ALU control decoder and performs the selected operation.
- Logic, shift, add/sub and slt operations complete in one cycle. mult and div run on an iterative 32-step engine that writes the Hi/Lo registers.
- A start/busy/done handshake lets the pipeline control stall the core while a mult or div is in progress.

Parameters:
- WIDTH, 32, operand/result width; mult/div iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ALU_Control  input  4  operation code (encoding below)
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- shamt  input  5  shift amount
- Result  output  WIDTH  registered single-cycle result
- Zero  output  1  registered (Result==0)
- Hi  output  WIDTH  mult high word / div remainder
- Lo  output  WIDTH  mult low word / div quotient
- busy  output  1  high while a mult/div is in progress
- done  output  1  one-cycle pulse when an accepted operation completes

Behaviour:
- Reset (synchronous, active-high, including mid-operation):
  - All outputs go to 0: Result, Zero, Hi, Lo, busy, done.
  - State goes to IDLE and any in-progress operation is abandoned.
- Opcodes:
  - 0000 and, 0001 or, 0010 add, 0110 sub, 0100 xor, 1100 nor.
  - 0111 slt: signed compare, Result = 1 or 0.
  - 1000 sll: B<<shamt. 1001 srl: B>>shamt, logical. 1010 sra: B>>>shamt, arithmetic.
  - 0101 mult: signed.
  - 1011 div: signed.
  - Any other code: Result = 0.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; there is no overflow flag.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 with a single-cycle op:
  - Result and Zero are registered at that edge.
  - done=1 for exactly the next cycle.
  - State stays IDLE. Hi and Lo are unchanged.
- IDLE, start=1 with mult or div:
  - Latch |A|, |B| and the sign flags. Set busy=1 and go to MUL or DIV.
  - Result and Zero keep their prior values for the whole mult/div operation.
- MUL:
  - Unsigned shift-add, one bit per cycle, WIDTH cycles, then go to FIX.
- DIV:
  - Restoring division, one quotient bit per cycle, WIDTH cycles, then go to FIX.
- FIX (one cycle):
  - mult: negate the 64-bit product if the operand signs differ, write {Hi,Lo}.
  - div: quotient is negated if signs differ (truncation toward zero); remainder takes the dividend's sign. Write Lo=quotient, Hi=remainder.
  - Clear busy, pulse done, return to IDLE.
- Latency:
  - Single-cycle ops: done is high in the cycle after the start sample edge.
  - mult/div: done is high WIDTH+2 cycles after the start sample edge (34 cycles at default WIDTH).
  - busy is high from the cycle after the start sample until the cycle done is high; it is low in the done cycle.
- Divide by zero:
  - Runs the full latency.
  - Lo = all ones, Hi = A unchanged.
- -2^31 / -1:
  - Lo = 0x80000000, Hi = 0. This falls out of magnitude arithmetic; no special case is needed.
- Handshake:
  - start while busy is ignored and the latched operands are unaffected.
  - start in the done cycle is accepted, because the state is IDLE.
  - Operands and ALU_Control need only be valid in the start cycle.
- Hi and Lo change only in FIX or on reset. Result and Zero change only on acceptance of a single-cycle op or on reset.

Test Plan:
- add: A=5, B=0xFFFFFFFF, ALU_Control=0010, start -> next cycle Result=4, Zero=0, done=1 for one cycle.
- sub and sra:
  - sub A=B=0x1234 -> Result=0, Zero=1.
  - sra B=0x80000000, shamt=4 -> Result=0xF8000000.
- mult: A=-3, B=7, code 0101 -> busy for 33 cycles; done at cycle 34 with Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Result unchanged.
- div:
  - A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - A=9, B=0 -> Lo=0xFFFFFFFF, Hi=9 after 34 cycles.
- Handshake: start a mult, then pulse start with add at cycle 10 -> add ignored, mult result correct, exactly one done pulse. A start in the done cycle is accepted.
- Reset mid-div at cycle 15 -> next cycle busy=0, done=0, Hi=Lo=0, Result=0. A subsequent mult of 6*7 gives Lo=42, Hi=0.

Source files
------------

// File: rtl/alu_muldiv_exec.sv
// Execute-stage ALU with an iterative signed mult/div engine.
// Single-cycle ops update Result/Zero; mult/div write Hi/Lo after WIDTH+2 cycles.
module alu_muldiv_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rem;

    logic [WIDTH-1:0] alu;
    logic             is_mul;
    logic             is_div;
    logic             last;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign is_mul = (ALU_Control == OP_MULT);
    assign is_div = (ALU_Control == OP_DIV);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign abs_a  = A[WIDTH-1] ? -A : A;
    assign abs_b  = B[WIDTH-1] ? -B : B;

    // One shift-add step: add multiplicand on multiplier LSB, shift pair right
    assign mul_sum = {1'b0, rem} + (q[0] ? {1'b0, mb} : '0);

    // One restoring-division step: shift next dividend bit in, trial subtract
    assign div_sh   = {rem, q[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b0, mb};

    // Sign correction applied in FIX; magnitude arithmetic covers MIN/-1
    assign prod     = {rem, q};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = div0 ? '1 : (neg_q ? -q : q);
    assign r_fix    = neg_r ? -rem : rem;

    // Single-cycle ALU result for the current opcode
    always_comb begin
        alu = '0;
        case (ALU_Control)
            OP_AND:  alu = A & B;
            OP_OR:   alu = A | B;
            OP_ADD:  alu = A + B;
            OP_SUB:  alu = A - B;
            OP_XOR:  alu = A ^ B;
            OP_NOR:  alu = ~(A | B);
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  alu = B << shamt;
            OP_SRL:  alu = B >> shamt;
            OP_SRA:  alu = WIDTH'($signed(B) >>> shamt);
            default: alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && is_mul)      state_nxt = MUL;
                else if (start && is_div) state_nxt = DIV;
            end
            MUL:     if (last) state_nxt = FIX;
            DIV:     if (last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
            Zero   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            mb     <= '0;
            q      <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (is_mul || is_div)) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        op_div <= is_div;
                        neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r  <= A[WIDTH-1];
                        div0   <= (B == '0);
                        mb     <= abs_b;
                        q      <= abs_a;
                        rem    <= '0;
                    end else if (start) begin
                        Result <= alu;
                        Zero   <= (alu == '0);
                        done   <= 1'b1;
                    end
                end
                MUL: begin
                    rem <= mul_sum[WIDTH:1];
                    q   <= {mul_sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    if (!div_diff[WIDTH+1]) begin
                        rem <= div_diff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_sh[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (op_div) begin
                        Lo <= q_fix;
                        Hi <= r_fix;
                    end else begin
                        Lo <= prod_fix[WIDTH-1:0];
                        Hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_exec.sv
// Directed scoreboard bench for alu_muldiv_exec.
// Expected results come from a behavioural model pushed at issue time.
module tb_alu_muldiv_exec;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] Result;
    logic        Zero;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          bsy;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_res  = '0;
    logic        m_zero = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    alu_muldiv_exec #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ALU_Control(ALU_Control), .A(A), .B(B), .shamt(shamt),
        .Result(Result), .Zero(Zero), .Hi(Hi), .Lo(Lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        int sa;
        int sb2;
        sa  = a;
        sb2 = b;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0100: return a ^ b;
            4'b1100: return ~(a | b);
            4'b0111: return (sa < sb2) ? 32'd1 : 32'd0;
            4'b1000: return b << sh;
            4'b1001: return b >> sh;
            4'b1010: return sb2 >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one start cycle (called at a negedge); push the expected outcome.
    task automatic issue(input string tag, input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        longint la, lb, lq, lr;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        e.lat = 34;
        e.bsy = 33;
        if (op == 4'b0101) begin
            p    = 64'(la * lb);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (op == 4'b1011) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else begin
                lq   = la / lb;
                lr   = la % lb;
                m_lo = lq[31:0];
                m_hi = lr[31:0];
            end
        end else begin
            m_res  = alu_ref(op, a, b, sh);
            m_zero = (m_res == 32'd0);
            e.lat  = 1;
            e.bsy  = 0;
        end
        e.tag  = tag;
        e.res  = m_res;
        e.zero = m_zero;
        e.hi   = m_hi;
        e.lo   = m_lo;
        sb.push_back(e);
        start       = 1'b1;
        ALU_Control = op;
        A           = a;
        B           = b;
        shamt       = sh;
        @(negedge clk);
        start       = 1'b0;
        A           = $urandom;
        B           = $urandom;
        ALU_Control = 4'($urandom);
    endtask

    // Wait for done (bounded), pop the scoreboard and compare everything.
    task automatic wait_done(input int n0);
        exp_t e;
        int n;
        int bz;
        n  = n0;
        bz = n0 - 1;
        while (!done && n < 100) begin
            if (busy) bz++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("timeout", 64'(done), 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_res"}, 64'(Result), 64'(e.res));
        chk({e.tag, "_zero"}, 64'(Zero), 64'(e.zero));
        chk({e.tag, "_hi"}, 64'(Hi), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(Lo), 64'(e.lo));
        chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({e.tag, "_busycyc"}, 64'(bz), 64'(e.bsy));
        chk({e.tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        issue(tag, op, a, b, sh);
        wait_done(1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ALU_Control = '0;
        A           = '0;
        B           = '0;
        shamt       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_zero", 64'(Zero), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);

        run("add", 4'b0010, 32'd5, 32'hFFFF_FFFF, 5'd0);
        run("sub", 4'b0110, 32'h1234, 32'h1234, 5'd0);
        run("sra", 4'b1010, 32'd0, 32'h8000_0000, 5'd4);
        run("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        run("or", 4'b0001, 32'hF000_0001, 32'h0000_1000, 5'd0);
        run("xor", 4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
        run("nor", 4'b1100, 32'h0000_00FF, 32'hFF00_0000, 5'd0);
        run("slt_t", 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
        run("slt_f", 4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0);
        run("sll", 4'b1000, 32'd0, 32'h8000_0003, 5'd31);
        run("srl", 4'b1001, 32'd0, 32'h8000_0000, 5'd4);
        run("undef", 4'b0011, 32'd7, 32'd9, 5'd3);
        run("add_nz", 4'b0010, 32'd1, 32'd2, 5'd0);

        run("mult", 4'b0101, 32'hFFFF_FFFD, 32'd7, 5'd0);
        run("div_neg", 4'b1011, 32'hFFFF_FFF9, 32'd2, 5'd0);
        run("div_zero", 4'b1011, 32'd9, 32'd0, 5'd0);
        run("div_zero_n", 4'b1011, 32'hFFFF_FFF7, 32'd0, 5'd0);
        run("div_min", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        run("div_rem", 4'b1011, 32'd100, 32'hFFFF_FFF9, 5'd0);
        run("mult_big", 4'b0101, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0);

        // start with add while mult busy: must be ignored
        issue("hs_mult", 4'b0101, 32'h0001_0003, 32'hFFFF_FF00, 5'd0);
        repeat (8) @(negedge clk);
        chk("hs_busy", 64'(busy), 64'd1);
        start       = 1'b1;
        ALU_Control = 4'b0010;
        A           = 32'd11;
        B           = 32'd22;
        @(negedge clk);
        start = 1'b0;
        wait_done(10);
        // start in the done cycle is accepted
        issue("hs_add", 4'b0010, 32'd40, 32'd2, 5'd0);
        wait_done(1);
        @(negedge clk);
        chk("hs_done_pulse", 64'(done), 64'd0);
        chk("hs_sb_empty", 64'(sb.size()), 64'd0);

        // reset in the middle of a divide
        issue("rst_div", 4'b1011, 32'd1000, 32'd3, 5'd0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_res  = '0;
        m_zero = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_hilo", {Hi, Lo}, 64'd0);
        chk("mrst_result", 64'(Result), 64'd0);
        run("mult_67", 4'b0101, 32'd6, 32'd7, 5'd0);
        chk("mult_67_lo", 64'(Lo), 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
